riscv_rvfi_stream_check: RTL

- Simulation-only checker on the core's RVFI retirement port, single retire per cycle (NRET=1).
- Checks ordering, PC continuity, x0 semantics, PC alignment, halt and forward progress on every retirement.
- Produces the 16-bit errcode consumed directly downstream by the rvfimon errcode assertion, which fatals on any nonzero value after reset.

---
 rtl/riscv_rvfi_stream_check.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_rvfi_stream_check.sv
// RVFI retirement stream checker (NRET=1): ordering, PC continuity, x0 reads/writes,
// next-PC alignment, post-halt retirement and forward-progress timeout.
module riscv_rvfi_stream_check #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1024,
  parameter int CEXT    = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic [31:0]     rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_halt,
  input  logic            rvfi_intr,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  output logic [15:0]     errcode,
  output logic [63:0]     err_order,
  output logic [31:0]     retire_count
);

  localparam logic [15:0] ERR_ORDER   = 16'h0101;
  localparam logic [15:0] ERR_PC      = 16'h0102;
  localparam logic [15:0] ERR_RD_X0   = 16'h0103;
  localparam logic [15:0] ERR_RS1_X0  = 16'h0104;
  localparam logic [15:0] ERR_RS2_X0  = 16'h0105;
  localparam logic [15:0] ERR_TIMEOUT = 16'h0106;
  localparam logic [15:0] ERR_ALIGN   = 16'h0107;
  localparam logic [15:0] ERR_HALTED  = 16'h0108;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_n;
  logic [15:0]       errcode_r;
  logic [15:0]       errcode_n;
  logic [63:0]       err_order_r;
  logic [63:0]       err_order_n;
  logic [31:0]       retire_count_r;
  logic [63:0]       exp_order_r;
  logic [XLEN-1:0]   exp_pc_r;
  logic              prev_trap_r;
  logic [31:0]       idle_cnt_r;
  logic [31:0]       idle_cnt_n;

  logic              valid_s;
  logic              order_fail_s;
  logic              pc_fail_s;
  logic              rd_fail_s;
  logic              rs1_fail_s;
  logic              rs2_fail_s;
  logic              misalign_s;
  logic              align_fail_s;
  logic [15:0]       chk_code_s;
  logic              timeout_hit_s;
  logic              accept_s;
  logic              unused_s;

  assign unused_s = ^rvfi_insn;

  // An X or Z on rvfi_valid must never look like a retirement.
  assign valid_s = (rvfi_valid === 1'b1);

  // Per-retirement checks, reduced to the lowest failing code.
  always_comb begin
    order_fail_s = 1'b0;
    pc_fail_s    = 1'b0;
    misalign_s   = 1'b0;
    chk_code_s   = 16'h0000;
    if (state_r == RUN) begin
      order_fail_s = (rvfi_order != exp_order_r);
      pc_fail_s    = !rvfi_intr && !prev_trap_r && (rvfi_pc_rdata != exp_pc_r);
    end else begin
      order_fail_s = 1'b0;
      pc_fail_s    = 1'b0;
    end
    rd_fail_s  = (rvfi_rd_addr  == 5'd0) && (rvfi_rd_wdata  != {XLEN{1'b0}});
    rs1_fail_s = (rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != {XLEN{1'b0}});
    rs2_fail_s = (rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != {XLEN{1'b0}});
    if (CEXT != 0) begin
      misalign_s = rvfi_pc_wdata[0];
    end else begin
      misalign_s = |rvfi_pc_wdata[1:0];
    end
    align_fail_s = misalign_s && !rvfi_trap;
    if (order_fail_s) begin
      chk_code_s = ERR_ORDER;
    end else if (pc_fail_s) begin
      chk_code_s = ERR_PC;
    end else if (rd_fail_s) begin
      chk_code_s = ERR_RD_X0;
    end else if (rs1_fail_s) begin
      chk_code_s = ERR_RS1_X0;
    end else if (rs2_fail_s) begin
      chk_code_s = ERR_RS2_X0;
    end else if (align_fail_s) begin
      chk_code_s = ERR_ALIGN;
    end else begin
      chk_code_s = 16'h0000;
    end
  end

  // Timeout fires on the idle cycle that would bring the counter up to TIMEOUT.
  always_comb begin
    if ((TIMEOUT != 0) && (state_r == RUN) && !valid_s) begin
      timeout_hit_s = (({1'b0, idle_cnt_r} + 33'd1) == 33'(TIMEOUT));
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, RUN: begin
        if (valid_s) begin
          if (chk_code_s != 16'h0000) begin
            state_n = ERROR;
          end else if (rvfi_halt) begin
            state_n = HALTED;
          end else begin
            state_n = RUN;
          end
        end else if (timeout_hit_s) begin
          state_n = ERROR;
        end else begin
          state_n = state_r;
        end
      end
      HALTED: begin
        if (valid_s) begin
          state_n = ERROR;
        end else begin
          state_n = HALTED;
        end
      end
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  // FSM output logic: error capture, retirement acceptance, idle counter.
  always_comb begin
    errcode_n   = errcode_r;
    err_order_n = err_order_r;
    accept_s    = 1'b0;
    idle_cnt_n  = idle_cnt_r;
    case (state_r)
      IDLE, RUN: begin
        if (valid_s) begin
          idle_cnt_n = 32'd0;
          if (chk_code_s != 16'h0000) begin
            errcode_n   = chk_code_s;
            err_order_n = rvfi_order;
          end else begin
            accept_s = 1'b1;
          end
        end else if (timeout_hit_s) begin
          errcode_n   = ERR_TIMEOUT;
          err_order_n = 64'd0;
        end else if ((state_r == RUN) && (idle_cnt_r != 32'hFFFF_FFFF)) begin
          idle_cnt_n = idle_cnt_r + 32'd1;
        end else begin
          idle_cnt_n = idle_cnt_r;
        end
      end
      HALTED: begin
        if (valid_s) begin
          errcode_n   = ERR_HALTED;
          err_order_n = rvfi_order;
        end else begin
          errcode_n   = errcode_r;
        end
      end
      ERROR:   errcode_n = errcode_r;
      default: errcode_n = errcode_r;
    endcase
  end

  // Datapath registers: outputs, baselines for the next retirement, counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      errcode_r      <= 16'h0000;
      err_order_r    <= 64'd0;
      retire_count_r <= 32'd0;
      exp_order_r    <= 64'd0;
      exp_pc_r       <= {XLEN{1'b0}};
      prev_trap_r    <= 1'b0;
      idle_cnt_r     <= 32'd0;
    end else begin
      errcode_r   <= errcode_n;
      err_order_r <= err_order_n;
      idle_cnt_r  <= idle_cnt_n;
      if (accept_s) begin
        exp_order_r <= rvfi_order + 64'd1;
        exp_pc_r    <= rvfi_pc_wdata;
        prev_trap_r <= rvfi_trap;
        if (retire_count_r != 32'hFFFF_FFFF) begin
          retire_count_r <= retire_count_r + 32'd1;
        end
      end
    end
  end

  assign errcode      = errcode_r;
  assign err_order    = err_order_r;
  assign retire_count = retire_count_r;

endmodule
